// File: rtl/demux1x8_frame_pkg.sv
// demux1x8_frame_pkg
// Shared definitions for the 1-to-8 frame demultiplexer.
// Contents:
//   LANES, SEL_W  - lane count and lane-select width
//   state_e       - frame FSM states (ST_FILL / ST_FULL)
//   ALL_WRITTEN   - written-mask value that completes a frame
//   laneOneHot()  - lane index to one-hot lane mask
package demux1x8_frame_pkg;

    localparam int LANES = 8;
    localparam int SEL_W = 3;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_FULL = 1'b1
    } state_e;

    localparam logic [LANES-1:0] ALL_WRITTEN = 8'hFF;

    function automatic logic [LANES-1:0] laneOneHot(input logic [SEL_W-1:0] idx);
        logic [LANES-1:0] mask;
        mask = '0;
        mask[idx] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/demux1x8_frame_lane.sv
// demux1x8_frame_lane (module lane_reg)
// One held output lane: a w-bit register with synchronous active-high
// reset and a write enable.
// Ports:
//   clk     - rising-edge clock
//   rst     - synchronous active-high reset, clears the lane to 0
//   wrEn_i  - load d_i at the next edge
//   d_i     - word to store
//   q_o     - held lane value
module lane_reg #(
    parameter int w = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wrEn_i,
    input  logic [w-1:0] d_i,
    output logic [w-1:0] q_o
);

    logic [w-1:0] data_q;

    // Lane storage: holds its value until reset or the next write.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
        end else if (wrEn_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/demux1x8_frame.sv
// demux1x8_frame
// Registered 1-to-8 demultiplexer / frame assembler. Words arriving over a
// valid/ready handshake are steered into one of eight held lanes, chosen by
// sel or, in auto mode, by an internal round-robin pointer. When all eight
// lanes have been written the frame is presented (frame_valid) and input is
// blocked until frame_ack.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   din, in_valid   - input word and its valid
//   in_ready        - block can accept a word (0 while rst or frame held)
//   sel, auto       - lane select / auto (round-robin) mode, per accepted word
//   frame_ack       - consumer has taken the frame
//   data0..data7    - held lane registers
//   lane_wr         - one-hot pulse for the lane written last cycle
//   written         - lanes written since the last ack
//   frame_valid     - full frame is being held
//   ptr             - round-robin pointer
//   ovw_err         - sticky overwrite flag (only with DEMUX_OVERWRITE_FLAG_EN)
// Optional feature macro: DEMUX_OVERWRITE_FLAG_EN
module demux1x8_frame
    import demux1x8_frame_pkg::*;
#(
    parameter int w = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [w-1:0]     din,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SEL_W-1:0] sel,
    input  logic             auto,
    input  logic             frame_ack,
    output logic [w-1:0]     data0,
    output logic [w-1:0]     data1,
    output logic [w-1:0]     data2,
    output logic [w-1:0]     data3,
    output logic [w-1:0]     data4,
    output logic [w-1:0]     data5,
    output logic [w-1:0]     data6,
    output logic [w-1:0]     data7,
    output logic [LANES-1:0] lane_wr,
    output logic [LANES-1:0] written,
`ifdef DEMUX_OVERWRITE_FLAG_EN
    output logic             ovw_err,
`endif
    output logic             frame_valid,
    output logic [SEL_W-1:0] ptr
);

    state_e           state_q, state_d;
    logic [LANES-1:0] written_q, written_d;
    logic [LANES-1:0] laneWr_q, laneWr_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic             accept;
    logic [SEL_W-1:0] targetLane;
    logic [LANES-1:0] targetMask;
    logic [w-1:0]     laneData [LANES];

    // in_ready is gated by rst so nothing is taken in a reset cycle.
    assign in_ready   = (state_q == ST_FILL) && !rst;
    assign accept     = in_valid && in_ready;
    assign targetLane = auto ? ptr_q : sel;
    assign targetMask = laneOneHot(targetLane);

    // Eight lane registers; each loads only when the accepted word targets it.
    for (genvar i = 0; i < LANES; i++) begin : gLanes
        lane_reg #(.w(w)) uLane (
            .clk    (clk),
            .rst    (rst),
            .wrEn_i (accept && (targetLane == SEL_W'(i))),
            .d_i    (din),
            .q_o    (laneData[i])
        );
    end

    // Next-state logic for the frame FSM, written mask, pointer and lane_wr
    // pulse. The FULL transition looks at the updated mask so that the edge
    // writing the last missing lane also raises the frame.
    always_comb begin
        state_d   = state_q;
        written_d = written_q;
        ptr_d     = ptr_q;
        laneWr_d  = '0;
        case (state_q)
            ST_FILL: begin
                if (accept) begin
                    written_d = written_q | targetMask;
                    laneWr_d  = targetMask;
                    if (auto) begin
                        ptr_d = ptr_q + 1'b1;
                    end
                    if (written_d == ALL_WRITTEN) begin
                        state_d = ST_FULL;
                    end
                end
            end
            ST_FULL: begin
                if (frame_ack) begin
                    written_d = '0;
                    ptr_d     = '0;
                    state_d   = ST_FILL;
                end
            end
            default: state_d = ST_FILL;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_FILL;
            written_q <= '0;
            ptr_q     <= '0;
            laneWr_q  <= '0;
        end else begin
            state_q   <= state_d;
            written_q <= written_d;
            ptr_q     <= ptr_d;
            laneWr_q  <= laneWr_d;
        end
    end

`ifdef DEMUX_OVERWRITE_FLAG_EN
    logic ovwErr_q, ovwErr_d;

    // Sticky overwrite flag: set by an accept into an already-written lane,
    // cleared when the frame is acknowledged. Accepts only happen in FILL and
    // acks only act in FULL, so set and clear never collide.
    always_comb begin
        ovwErr_d = ovwErr_q;
        if ((state_q == ST_FULL) && frame_ack) begin
            ovwErr_d = 1'b0;
        end else if (accept && ((written_q & targetMask) != '0)) begin
            ovwErr_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovwErr_q <= 1'b0;
        end else begin
            ovwErr_q <= ovwErr_d;
        end
    end

    assign ovw_err = ovwErr_q;
`endif

    assign data0       = laneData[0];
    assign data1       = laneData[1];
    assign data2       = laneData[2];
    assign data3       = laneData[3];
    assign data4       = laneData[4];
    assign data5       = laneData[5];
    assign data6       = laneData[6];
    assign data7       = laneData[7];
    assign lane_wr     = laneWr_q;
    assign written     = written_q;
    assign frame_valid = (state_q == ST_FULL);
    assign ptr         = ptr_q;

endmodule

// File: tb/tb_demux1x8_frame.sv
// tb_demux1x8_frame
// Randomized plus directed bench for demux1x8_frame. A behavioural model
// (arrays of lane values and written flags, an integer pointer) tracks what
// the outputs must be; a compare process checks every output on each falling
// edge, and directed sequences pin the model with literal expectations.
module tb_demux1x8_frame;

    logic       clk;
    logic       rst;
    logic [7:0] din;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] sel;
    logic       auto;
    logic       frame_ack;
    logic [7:0] data0, data1, data2, data3, data4, data5, data6, data7;
    logic [7:0] lane_wr;
    logic [7:0] written;
    logic       frame_valid;
    logic [2:0] ptr;
`ifdef DEMUX_OVERWRITE_FLAG_EN
    logic       ovw_err;
`endif

    int assertCount = 0;
    int failCount   = 0;
    bit checkEn     = 0;

    // Behavioural model state
    int mData [8];
    bit mWritten [8];
    int mPtr;
    bit mFull;
    int mLastLane;   // -1 when no word was accepted at the last edge
    bit mOvw;

    demux1x8_frame #(.w(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .sel         (sel),
        .auto        (auto),
        .frame_ack   (frame_ack),
        .data0       (data0),
        .data1       (data1),
        .data2       (data2),
        .data3       (data3),
        .data4       (data4),
        .data5       (data5),
        .data6       (data6),
        .data7       (data7),
        .lane_wr     (lane_wr),
        .written     (written),
`ifdef DEMUX_OVERWRITE_FLAG_EN
        .ovw_err     (ovw_err),
`endif
        .frame_valid (frame_valid),
        .ptr         (ptr)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Reference model, advanced at each rising edge from the inputs that
    // were stable before the edge.
    always @(posedge clk) begin
        int lane;
        int cnt;
        mLastLane = -1;
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                mData[i]    = 0;
                mWritten[i] = 0;
            end
            mPtr  = 0;
            mFull = 0;
            mOvw  = 0;
        end else if (mFull) begin
            if (frame_ack) begin
                for (int i = 0; i < 8; i++) mWritten[i] = 0;
                mPtr  = 0;
                mFull = 0;
                mOvw  = 0;
            end
        end else if (in_valid) begin
            lane = auto ? mPtr : int'(sel);
            if (mWritten[lane]) mOvw = 1;
            mData[lane]    = int'(din);
            mWritten[lane] = 1;
            mLastLane      = lane;
            if (auto) mPtr = (mPtr + 1) % 8;
            cnt = 0;
            for (int i = 0; i < 8; i++) cnt += mWritten[i];
            if (cnt == 8) mFull = 1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    function automatic logic [7:0] dutLane(input int i);
        case (i)
            0: return data0;
            1: return data1;
            2: return data2;
            3: return data3;
            4: return data4;
            5: return data5;
            6: return data6;
            default: return data7;
        endcase
    endfunction

    // Compare process: every output against the model on each falling edge.
    always @(negedge clk) begin
        logic [7:0] expWritten;
        logic [7:0] expLaneWr;
        if (checkEn) begin
            expWritten = '0;
            for (int i = 0; i < 8; i++) begin
                expWritten[i] = mWritten[i];
                checkOutput($sformatf("data%0d", i), 32'(dutLane(i)), 32'(mData[i]));
            end
            expLaneWr = '0;
            if (mLastLane >= 0) expLaneWr[mLastLane] = 1'b1;
            checkOutput("written", 32'(written), 32'(expWritten));
            checkOutput("lane_wr", 32'(lane_wr), 32'(expLaneWr));
            checkOutput("ptr", 32'(ptr), 32'(mPtr));
            checkOutput("frame_valid", 32'(frame_valid), 32'(mFull));
            checkOutput("in_ready", 32'(in_ready), 32'(!rst && !mFull));
`ifdef DEMUX_OVERWRITE_FLAG_EN
            checkOutput("ovw_err", 32'(ovw_err), 32'(mOvw));
`endif
        end
    end

    // Drive one cycle of inputs, then return #1 after the rising edge.
    task automatic applyStimulus(input logic r, input logic v, input logic [7:0] d,
                                 input logic a, input logic [2:0] s, input logic ack);
        rst       = r;
        in_valid  = v;
        din       = d;
        auto      = a;
        sel       = s;
        frame_ack = ack;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        applyStimulus(1, 0, 8'h00, 0, 3'd0, 0);
    endtask

    initial begin
        logic [7:0] autoVals [8];
        logic [2:0] manSel [8];
        autoVals = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
        manSel   = '{3'd7, 3'd3, 3'd0, 3'd5, 3'd1, 3'd6, 3'd2, 3'd4};

        rst = 1; in_valid = 0; din = 0; auto = 0; sel = 0; frame_ack = 0;
        doReset();
        checkEn = 1;
        checkOutput("reset written", 32'(written), 32'h0);
        checkOutput("reset frame_valid", 32'(frame_valid), 32'h0);
        checkOutput("reset data3", 32'(data3), 32'h0);

        // Auto fill
        for (int i = 0; i < 8; i++) applyStimulus(0, 1, autoVals[i], 1, 3'd5, 0);
        checkOutput("auto data0", 32'(data0), 32'h80);
        checkOutput("auto data7", 32'(data7), 32'h01);
        checkOutput("auto lane_wr", 32'(lane_wr), 32'h80);
        checkOutput("auto written", 32'(written), 32'hFF);
        checkOutput("auto ptr", 32'(ptr), 32'h0);
        checkOutput("auto frame_valid", 32'(frame_valid), 32'h1);
        checkOutput("auto in_ready", 32'(in_ready), 32'h0);

        // Backpressure while FULL, then ack with a word presented
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 8'hAA, 1, 3'd0, 0);
        checkOutput("bp data0", 32'(data0), 32'h80);
        checkOutput("bp lane_wr", 32'(lane_wr), 32'h0);
        applyStimulus(0, 1, 8'hAA, 1, 3'd0, 1);
        checkOutput("ack in_ready", 32'(in_ready), 32'h1);
        checkOutput("ack written", 32'(written), 32'h0);
        checkOutput("ack data0", 32'(data0), 32'h80);
        applyStimulus(0, 1, 8'hAA, 1, 3'd0, 0);
        checkOutput("post-ack data0", 32'(data0), 32'hAA);
        checkOutput("post-ack lane_wr", 32'(lane_wr), 32'h01);

        // Manual out-of-order fill
        doReset();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 1, 8'h10 + 8'(manSel[i]), 0, manSel[i], 0);
            checkOutput("manual lane_wr", 32'(lane_wr), 32'(8'h01 << manSel[i]));
        end
        checkOutput("manual data5", 32'(data5), 32'h15);
        checkOutput("manual data0", 32'(data0), 32'h10);
        checkOutput("manual ptr", 32'(ptr), 32'h0);
        checkOutput("manual frame_valid", 32'(frame_valid), 32'h1);
        applyStimulus(0, 0, 8'h00, 0, 3'd0, 1);

        // Overwrite of lane 2
        applyStimulus(0, 1, 8'h11, 0, 3'd2, 0);
        applyStimulus(0, 1, 8'h22, 0, 3'd2, 0);
        checkOutput("ovw data2", 32'(data2), 32'h22);
        checkOutput("ovw written", 32'(written), 32'h04);
        checkOutput("ovw frame_valid", 32'(frame_valid), 32'h0);
`ifdef DEMUX_OVERWRITE_FLAG_EN
        checkOutput("ovw flag", 32'(ovw_err), 32'h1);
`endif

        // Reset mid-fill
        doReset();
        for (int i = 0; i < 5; i++) applyStimulus(0, 1, 8'h30 + 8'(i), 1, 3'd0, 0);
        checkOutput("midfill ptr", 32'(ptr), 32'h5);
        doReset();
        checkOutput("midfill rst data4", 32'(data4), 32'h0);
        checkOutput("midfill rst ptr", 32'(ptr), 32'h0);
        applyStimulus(0, 1, 8'h5A, 1, 3'd6, 0);
        checkOutput("midfill after data0", 32'(data0), 32'h5A);

        // Mixed auto/manual fill
        doReset();
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 8'h40 + 8'(i), 1, 3'd7, 0);
        for (int s = 3; s < 8; s++) applyStimulus(0, 1, 8'h50 + 8'(s), 0, 3'(s), 0);
        checkOutput("mixed frame_valid", 32'(frame_valid), 32'h1);
        checkOutput("mixed ptr", 32'(ptr), 32'h3);
        applyStimulus(0, 1, 8'hEE, 1, 3'd0, 0);
        checkOutput("mixed held data3", 32'(data3), 32'h53);
        checkOutput("mixed held lane_wr", 32'(lane_wr), 32'h0);

        // Randomized traffic; the compare process checks every cycle.
        doReset();
        for (int c = 0; c < 2000; c++) begin
            applyStimulus(($urandom_range(0, 99) == 0),
                          ($urandom_range(0, 3) != 0),
                          8'($urandom),
                          ($urandom_range(0, 1) == 1),
                          3'($urandom_range(0, 7)),
                          ($urandom_range(0, 3) == 0));
        end

        checkEn = 0;
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/demux1x8_frame.md
Name: demux1x8_frame

Overview:
- Registered 1-to-8 demultiplexer/frame assembler; inverse of the 8:1 data mux.
- Accepts a stream of W-bit words over a valid/ready handshake and steers each into one of eight held output lanes.
- Lane is chosen by an explicit select, or by an internal round-robin pointer in auto mode.
- Once all eight lanes are written, presents the frame and blocks input until acknowledged. Feeds mux8x1-style consumers that read lanes in parallel.

Parameters:
- w, 8, data width of input word and each output lane.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- din  input  w  input word.
- in_valid  input  1  din valid this cycle.
- in_ready  output  1  block can accept a word.
- sel  input  3  target lane when auto=0.
- auto  input  1  1: lane = internal pointer; 0: lane = sel. Sampled per accepted word.
- frame_ack  input  1  consumer has taken the frame.
- data0..data7  output  w each  held lane registers.
- lane_wr  output  8  one-hot, one-cycle pulse marking the lane written last cycle.
- written  output  8  mask of lanes written since last ack.
- frame_valid  output  1  all eight lanes written; frame held.
- ptr  output  3  current round-robin pointer.

Behaviour:
- Reset (rst=1 at clk edge):
  - data0..7=0, written=0, ptr=0, lane_wr=0, state=FILL, frame_valid=0.
  - in_ready forced 0 while rst is high.
- States:
  - FILL: in_ready=1.
  - FULL: in_ready=0, frame_valid=1.
- Accept = in_valid & in_ready. On accept at edge k:
  - target lane L = auto ? ptr : sel.
  - data[L]<=din; written[L]<=1; lane_wr<=onehot(L) visible after edge k for exactly one cycle.
  - Single-cycle latency: data visible the cycle after accept.
- ptr advances (+1, wraps 7->0) only on an accept with auto=1. Manual accepts leave ptr unchanged.
- Manual write to an already-written lane overwrites the data; written is unchanged.
- FILL->FULL at the edge where written becomes 8'hFF.
  - Covers mixed auto/manual fills.
  - frame_valid rises the cycle after the 8th distinct lane is written.
- FULL:
  - in_valid is ignored; no data change.
  - frame_ack=1 at an edge: written<=0, ptr<=0, state<=FILL. Data lanes keep their values.
  - A word presented in the ack cycle is not accepted (in_ready=0 that cycle); it is accepted the next cycle.
- frame_ack in FILL: no effect.
- Reset mid-fill clears everything immediately, including a partially written frame. There are no pending words.
- lane_wr is 0 in every cycle with no accept.

Optional Feature:
- Macro DEMUX_OVERWRITE_FLAG_EN.
- Defined:
  - Extra output ovw_err (1 bit), sticky.
  - Set at the edge of any accept whose target lane already has written[L]=1.
  - Cleared by rst or frame_ack.
- Undefined: port absent; overwrites are silent.

Decomposition:
- Shared include demux_defs.vh:
  - LANES=8, SEL_W=3.
  - State encodings ST_FILL=1'b0, ST_FULL=1'b1.
  - ALL_WRITTEN=8'hFF.
- Sub-module lane_reg:
  - w-bit register with synchronous reset and write enable, instantiated 8x.
  - Enable = accept & (L==i).
- Top holds FSM, ptr, written mask, and optional flag.

Test Plan:
- Auto fill: rst, then auto=1, in_valid=1, din=8'h80,40,20,10,08,04,02,01 on 8 consecutive cycles -> data0..7 equal those values, ptr wraps to 0, written=FF, frame_valid=1 one cycle after the last accept, in_ready=0.
- Backpressure: while FULL, drive din=8'hAA, in_valid=1 for 3 cycles -> no lane changes, lane_wr=0. Then frame_ack=1 -> next cycle in_ready=1, written=0, data unchanged; 8'hAA is accepted into data0 on the following cycle.
- Manual out-of-order: auto=0, sel=7,3,0,5,1,6,2,4 with din=sel+8'h10 -> each dataN=N+8'h10, lane_wr one-hot matches sel, frame_valid after 8th write, ptr stays 0.
- Overwrite: manual sel=2 with din=8'h11, then sel=2 with din=8'h22 -> data2=8'h22, written=8'h04, no FULL. With DEMUX_OVERWRITE_FLAG_EN, ovw_err=1 after the 2nd write and stays set until ack.
- Reset mid-fill: after 5 auto writes, rst=1 for one cycle -> all data=0, written=0, ptr=0. A following auto write lands in data0.
- Mixed: 3 auto writes (lanes 0-2), manual writes sel=3..7, then auto write -> that auto write lands in lane 3 (ptr=3) only if still FILL. Expected: FULL is reached after the sel=7 write and the auto write is held off.
